// File: rtl/misr_analyzer.sv
// misr_analyzer: BIST output-response analyzer.
// Compresses NUM_PATTERNS response words into a Galois MISR, then compares
// the final signature against GOLDEN and reports done / pass_nfail.
// Optional build macro: MISR_XMASK_EN -- when defined, response bits cleared
// in XMASK are forced to 0 before they enter the signature.
module misr_analyzer #(
  parameter int unsigned      WIDTH        = 32'd8,
  parameter logic [WIDTH-1:0] POLY         = 8'h1D,
  parameter logic [WIDTH-1:0] SEED         = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] GOLDEN       = {WIDTH{1'b0}},
  parameter int unsigned      NUM_PATTERNS = 32'd127,
  parameter logic [WIDTH-1:0] XMASK        = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic             pass_nfail,
  output logic [WIDTH-1:0] signature
);

  localparam int unsigned      CNT_W    = $clog2(NUM_PATTERNS + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 32'd1);

`ifdef MISR_XMASK_EN
  // X-prone CUT bits are blanked so they cannot corrupt the signature
  localparam logic [WIDTH-1:0] CAPTURE_MASK = XMASK;
`else
  // Masking is compiled out: every bit is captured and XMASK has no effect
  localparam logic [WIDTH-1:0] CAPTURE_MASK = {WIDTH{1'b1}} | XMASK;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sig_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             pass_r;
  logic [WIDTH-1:0] capt_data_s;

  // One Galois MISR step: shift, fold the msb back through the taps, add data
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    misr_next = {sig[WIDTH-2:0], 1'b0} ^ fb ^ d;
  endfunction

  assign capt_data_s = data_in & CAPTURE_MASK;

  // Run-control FSM with the signature register, pattern counter and result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sig_r   <= SEED;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else if (start) begin
      // Start wins over capture; the word on data_in this cycle is dropped
      state_r <= ST_CAPTURE;
      sig_r   <= SEED;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sig_r <= SEED;
          cnt_r <= {CNT_W{1'b0}};
        end
        ST_CAPTURE: begin
          if (enable) begin
            sig_r <= misr_next(sig_r, capt_data_s);
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_COMPARE;
            end else begin
              state_r <= ST_CAPTURE;
            end
          end else begin
            sig_r <= sig_r;
            cnt_r <= cnt_r;
          end
        end
        ST_COMPARE: begin
          pass_r  <= (sig_r == GOLDEN);
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          sig_r   <= SEED;
          cnt_r   <= {CNT_W{1'b0}};
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign done       = done_r;
  assign pass_nfail = pass_r;
  assign signature  = sig_r;

endmodule

// File: tb/tb_misr_analyzer.sv
// Directed testbench for misr_analyzer (WIDTH=4, POLY=4'b0011, GOLDEN=4'h3).
// u_main: NUM_PATTERNS=3; u_fb: NUM_PATTERNS=2; u_xm: XMASK=4'b1110.
module tb_misr_analyzer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, enable;
  logic [3:0] data_in;
  logic       done, pass_nfail;
  logic [3:0] signature;

  logic       fb_start, fb_enable;
  logic [3:0] fb_data;
  logic       fb_done, fb_pass;
  logic [3:0] fb_sig;

  logic       xm_start, xm_enable;
  logic [3:0] xm_data;
  logic       xm_done, xm_pass;
  logic [3:0] xm_sig;

  int tests_run = 0;
  int fail_cnt  = 0;

  misr_analyzer #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .GOLDEN(4'h3),
                  .NUM_PATTERNS(3), .XMASK(4'b1111)) u_main (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .data_in(data_in),
    .done(done), .pass_nfail(pass_nfail), .signature(signature));

  misr_analyzer #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .GOLDEN(4'h3),
                  .NUM_PATTERNS(2), .XMASK(4'b1111)) u_fb (
    .clk(clk), .reset(reset), .start(fb_start), .enable(fb_enable), .data_in(fb_data),
    .done(fb_done), .pass_nfail(fb_pass), .signature(fb_sig));

  misr_analyzer #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .GOLDEN(4'h3),
                  .NUM_PATTERNS(3), .XMASK(4'b1110)) u_xm (
    .clk(clk), .reset(reset), .start(xm_start), .enable(xm_enable), .data_in(xm_data),
    .done(xm_done), .pass_nfail(xm_pass), .signature(xm_sig));

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (done !== 1'b0 || pass_nfail !== 1'b0 || signature !== 4'h0) begin
      fail_cnt++;
      $display("FAIL reset_values: done=%b pass=%b sig=%h, want 0 0 0", done, pass_nfail, signature);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable  = ~enable;
      data_in = 4'(i + 5);
      tick();
      tests_run++;
      if (done !== 1'b0 || pass_nfail !== 1'b0 || signature !== 4'h0) begin
        fail_cnt++;
        $display("FAIL idle_hold[%0d]: done=%b pass=%b sig=%h, want 0 0 0", i, done, pass_nfail, signature);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_pass();
    logic [3:0] words [3];
    logic [3:0] exp_sig [3];
    words   = '{4'h1, 4'h2, 4'h3};
    exp_sig = '{4'h1, 4'h0, 4'h3};
    start = 1'b1;
    tick();
    start  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = words[i];
      tick();
      tests_run++;
      if (signature !== exp_sig[i] || done !== 1'b0) begin
        fail_cnt++;
        $display("FAIL pass_sig[%0d]: sig=%h done=%b, want %h 0", i, signature, done, exp_sig[i]);
      end
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1 || pass_nfail !== 1'b1 || signature !== 4'h3) begin
      fail_cnt++;
      $display("FAIL pass_result: done=%b pass=%b sig=%h, want 1 1 3", done, pass_nfail, signature);
    end
    for (int i = 0; i < 3; i++) begin
      enable  = ~enable;
      data_in = 4'hF;
      tick();
      tests_run++;
      if (done !== 1'b1 || pass_nfail !== 1'b1 || signature !== 4'h3) begin
        fail_cnt++;
        $display("FAIL pass_hold[%0d]: done=%b pass=%b sig=%h, want 1 1 3", i, done, pass_nfail, signature);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_fail_gaps();
    start = 1'b1;
    tick();
    tests_run++;
    if (done !== 1'b0 || pass_nfail !== 1'b0 || signature !== 4'h0) begin
      fail_cnt++;
      $display("FAIL gap_reseed: done=%b pass=%b sig=%h, want 0 0 0", done, pass_nfail, signature);
    end
    start   = 1'b0;
    enable  = 1'b1;
    data_in = 4'h1;
    tick();
    enable  = 1'b0;
    data_in = 4'h7;
    tick();
    tick();
    tests_run++;
    if (signature !== 4'h1 || done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL gap_hold: sig=%h done=%b, want 1 0", signature, done);
    end
    enable  = 1'b1;
    data_in = 4'h2;
    tick();
    tick();
    enable = 1'b0;
    tests_run++;
    if (signature !== 4'h2 || done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL gap_last_word: sig=%h done=%b, want 2 0", signature, done);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || pass_nfail !== 1'b0 || signature !== 4'h2) begin
      fail_cnt++;
      $display("FAIL gap_result: done=%b pass=%b sig=%h, want 1 0 2", done, pass_nfail, signature);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    start   = 1'b0;
    enable  = 1'b1;
    data_in = 4'h1;
    tick();
    data_in = 4'h2;
    tick();
    start   = 1'b1;
    data_in = 4'h5;
    tick();
    tests_run++;
    if (signature !== 4'h0 || done !== 1'b0 || pass_nfail !== 1'b0) begin
      fail_cnt++;
      $display("FAIL restart_reseed: sig=%h done=%b pass=%b, want 0 0 0", signature, done, pass_nfail);
    end
    start   = 1'b0;
    data_in = 4'h1;
    tick();
    data_in = 4'h2;
    tick();
    data_in = 4'h3;
    tick();
    enable = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1 || pass_nfail !== 1'b1 || signature !== 4'h3) begin
      fail_cnt++;
      $display("FAIL restart_result: done=%b pass=%b sig=%h, want 1 1 3", done, pass_nfail, signature);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (done !== 1'b0 || pass_nfail !== 1'b0 || signature !== 4'h0) begin
      fail_cnt++;
      $display("FAIL done_restart: done=%b pass=%b sig=%h, want 0 0 0", done, pass_nfail, signature);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    tick();
    start   = 1'b0;
    enable  = 1'b1;
    data_in = 4'h9;
    tick();
    tests_run++;
    if (signature !== 4'h9) begin
      fail_cnt++;
      $display("FAIL midrun_capture: sig=%h, want 9", signature);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (signature !== 4'h0 || done !== 1'b0 || pass_nfail !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midrun_reset: sig=%h done=%b pass=%b, want 0 0 0", signature, done, pass_nfail);
    end
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (signature !== 4'h0 || done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midrun_idle: sig=%h done=%b, want 0 0", signature, done);
    end
    enable = 1'b0;
  endtask

  task automatic test_feedback();
    fb_start = 1'b1;
    tick();
    fb_start  = 1'b0;
    fb_enable = 1'b1;
    fb_data   = 4'h8;
    tick();
    tests_run++;
    if (fb_sig !== 4'h8) begin
      fail_cnt++;
      $display("FAIL fb_first: sig=%h, want 8", fb_sig);
    end
    fb_data = 4'h0;
    tick();
    fb_enable = 1'b0;
    tests_run++;
    if (fb_sig !== 4'h3 || fb_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL fb_taps: sig=%h done=%b, want 3 0", fb_sig, fb_done);
    end
    tick();
    tests_run++;
    if (fb_done !== 1'b1 || fb_pass !== 1'b1) begin
      fail_cnt++;
      $display("FAIL fb_result: done=%b pass=%b, want 1 1", fb_done, fb_pass);
    end
  endtask

  task automatic test_xmask();
    logic [3:0] exp_sig;
    logic       exp_pass;
`ifdef MISR_XMASK_EN
    exp_sig  = 4'h6;
    exp_pass = 1'b0;
`else
    exp_sig  = 4'h3;
    exp_pass = 1'b1;
`endif
    xm_start = 1'b1;
    tick();
    xm_start  = 1'b0;
    xm_enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      xm_data = 4'(i);
      tick();
    end
    xm_enable = 1'b0;
    tests_run++;
    if (xm_sig !== exp_sig) begin
      fail_cnt++;
      $display("FAIL xmask_sig: sig=%h, want %h", xm_sig, exp_sig);
    end
    tick();
    tests_run++;
    if (xm_done !== 1'b1 || xm_pass !== exp_pass) begin
      fail_cnt++;
      $display("FAIL xmask_result: done=%b pass=%b, want 1 %b", xm_done, xm_pass, exp_pass);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; enable = 1'b0; data_in = 4'h0;
    fb_start = 1'b0; fb_enable = 1'b0; fb_data = 4'h0;
    xm_start = 1'b0; xm_enable = 1'b0; xm_data = 4'h0;
    #2;
    test_reset();
    test_pass();
    test_fail_gaps();
    test_restart();
    test_reset_mid_run();
    test_feedback();
    test_xmask();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/misr_analyzer.md
# misr_analyzer

Output-response analyzer for the BIST path: the compacting end of the LFSR pattern generator. It compresses the circuit-under-test response words into a multiple-input signature register (MISR) over a fixed number of patterns. It then compares the final signature against a golden value and reports `done` / `pass_nfail` to the BIST controller and top level.

## Interface
- `WIDTH`, 8: response word and signature width (≥2).
- `POLY`, 8'h1D: feedback taps, bit i = coefficient of x^i, x^WIDTH implicit; `POLY[0]` must be 1.
- `SEED`, 0: signature value loaded at reset and at each start.
- `GOLDEN`, 0: expected final signature.
- `NUM_PATTERNS`, 127: response words compressed per run (≥1).
- `XMASK`, all ones: per-bit capture mask, used only with `MISR_XMASK_EN`.
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: level, sampled each cycle; high reseeds and starts a run.
- `enable`  in  1: response word valid this cycle (controller `running`).
- `data_in`  in  WIDTH: CUT response word.
- `done`  out  1: registered; run complete, result valid.
- `pass_nfail`  out  1: registered; 1 = signature matched `GOLDEN`.
- `signature`  out  WIDTH: current signature register.

## Operation
- FSM states: IDLE, CAPTURE, COMPARE, DONE.
- IDLE: `sig`=SEED, `cnt`=0. `start`=1 → CAPTURE, with `sig`<=SEED and `cnt`<=0.
- CAPTURE: each cycle with `enable`=1, `sig` updates and `cnt`<=`cnt`+1. When `enable`=1 and `cnt`==NUM_PATTERNS-1 → COMPARE. Cycles with `enable`=0 hold `sig` and `cnt`.
- MISR update (Galois, msb = `sig[WIDTH-1]`): `next[i] = sig[i-1] ^ (POLY[i] & msb) ^ d[i]`, with `sig[-1]`=0. `d` = `data_in` (masked per Configuration). Equivalently `next = (sig<<1) ^ (msb ? POLY : 0) ^ d`, truncated to WIDTH.
- COMPARE: `pass_nfail`<=(`sig`==GOLDEN), `done`<=1, → DONE. `sig` is not updated.
- DONE: hold `sig`, `done`=1, `pass_nfail`. `start`=1 → CAPTURE (reseed, `cnt`=0, `done`<=0, `pass_nfail`<=0).
- `start`=1 while in CAPTURE or COMPARE: restart. Reseed, `cnt`=0, stay in or go to CAPTURE, `done`/`pass_nfail` <=0. `start` has priority over capture in the same cycle; `data_in` that cycle is discarded.
- `enable` is ignored outside CAPTURE.
- Counter width `$clog2(NUM_PATTERNS+1)`; it never wraps, because the FSM leaves CAPTURE at terminal count.

## Timing
- Reset values: state IDLE, `sig`=SEED (so `signature`=SEED), `cnt`=0, `done`=0, `pass_nfail`=0.
- `reset` is dominant over all inputs. Asserted mid-run, the next edge returns to reset values with no partial result.
- `start` high at edge T → CAPTURE from T. The first word can be captured at edge T+1.
- Final capture at edge N → COMPARE during N..N+1. At edge N+1, `done`=1 and `pass_nfail` are valid, one cycle after the last word.
- Minimum run: NUM_PATTERNS+2 edges from `start` to `done`.
- `done` and `pass_nfail` change only together and only on FSM transitions. `pass_nfail` is never 1 while `done`=0.
- `signature` reflects `sig` combinationally from the register, updated the edge after each enabled capture.

## Configuration
- `MISR_XMASK_EN` defined: `d = data_in & XMASK`. Masked (unknown/X-prone) CUT bits contribute 0 to the signature.
- Not defined: `d = data_in`, and `XMASK` is unused. Behaviour is otherwise identical.

## Test plan
All scenarios use WIDTH=4, POLY=4'b0011, SEED=0, GOLDEN=4'h3, NUM_PATTERNS=3, unless stated.
- Reset: hold `reset` 2 cycles → `done`=0, `pass_nfail`=0, `signature`=0, and they stay there with `enable` toggling and no `start`.
- Pass: `start` pulse, then `enable`=1 with data 1,2,3 on consecutive cycles → `signature` sequence 1,0,3. `done`=1 and `pass_nfail`=1 one cycle after the 3rd word; both held until the next `start`.
- Fail plus gaps: data 1,2,2 with `enable` low for 2 cycles between words 1 and 2 → final `signature`=4'h2, `done`=1, `pass_nfail`=0, and `done` is delayed by exactly the 2 gap cycles.
- Feedback: NUM_PATTERNS=2, data 8,0 → `signature` 8 then 3 (taps applied on msb), `pass_nfail`=1.
- Restart: `start` after word 2 of a run, then data 1,2,3 → reseeded to 0 and `pass_nfail`=1. Separately, `reset` mid-run → `signature`=0 and `done`=0 next cycle.
- `MISR_XMASK_EN` with XMASK=4'b1110: data 1,2,3 → masked words 0,2,2, final `signature`=4'h6, `pass_nfail`=0. Without the macro, the same stimulus passes.
